// File: rtl/reflet_fetch_pkg.sv
// reflet_fetch_pkg: shared widths, FSM states and prefetch entry type for the fetch stage
package reflet_fetch_pkg;
  localparam int BYTE_ADDR_W = 16;
  localparam int WORD_ADDR_W = 15;
  typedef enum logic {WAIT_MEM, FETCH} state_t;
  typedef struct packed {
    logic [BYTE_ADDR_W-1:0] pc;
    logic [7:0]             ins;
  } entry_t;
endpackage

// File: rtl/reflet_fetch_fifo.sv
// reflet_fetch_fifo: shift-register byte FIFO, 0/1/2-byte push, 1-byte pop, flush; head is q[0]
module reflet_fetch_fifo
  import reflet_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               push_n,
  input  entry_t                   din0,
  input  entry_t                   din1,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  entry_t q [DEPTH];
  entry_t nq [DEPTH];
  logic [CW-1:0] base;
  always_comb begin
    base = count - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      nq[i] = pop ? ((i < DEPTH - 1) ? q[(i + 1) % DEPTH] : '0) : q[i];
      if (push_n != 2'd0 && i == int'(base)) nq[i] = din0;
      if (push_n == 2'd2 && i == int'(base) + 1) nq[i] = din1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      q     <= '{default: '0};
    end else begin
      count <= base + CW'(push_n);
      q     <= nq;
    end
  end
  assign head = q[0];
endmodule

// File: rtl/reflet_fetch16.sv
// reflet_fetch16: fetch stage splitting 16-bit memory words into a byte stream with redirect support
module reflet_fetch16
  import reflet_fetch_pkg::*;
#(
  parameter int                     FIFO_DEPTH = 4,
  parameter logic [BYTE_ADDR_W-1:0] RESET_PC   = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_ready,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic                   mem_enable,
  input  logic [15:0]            mem_data,
  input  logic                   redirect,
  input  logic [BYTE_ADDR_W-1:0] redirect_pc,
  output logic [7:0]             inst_out,
  output logic [BYTE_ADDR_W-1:0] inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_accept
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t                 state;
  logic                   armed, in_flight, in_odd, kill;
  logic [BYTE_ADDR_W-1:0] fetch_pc, in_pc;
  logic [CW-1:0]          count;
  logic [1:0]             push_n;
  entry_t                 head, din0, din1;
  // WAIT_MEM issues on the cycle inst_ready rises, except on the first cycle out of reset
  assign mem_enable = inst_ready && (state == FETCH || armed) && !redirect &&
                      (int'(count) + (in_flight ? (in_odd ? 1 : 2) : 0) <= FIFO_DEPTH - 2);
  assign mem_addr   = mem_enable ? fetch_pc[BYTE_ADDR_W-1:1] : '0;
  assign push_n     = (in_flight && !kill) ? (in_odd ? 2'd1 : 2'd2) : 2'd0;
  assign din0       = in_odd ? {in_pc, mem_data[15:8]} : {in_pc, mem_data[7:0]};
  assign din1       = {in_pc + 16'd1, mem_data[15:8]};
  assign inst_valid = count != '0;
  assign inst_out   = head.ins;
  assign inst_pc    = head.pc;
  reflet_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (redirect),
    .push_n (push_n),
    .din0   (din0),
    .din1   (din1),
    .pop    (inst_valid && inst_accept),
    .head   (head),
    .count  (count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_MEM;
      armed     <= 1'b0;
      in_flight <= 1'b0;
      in_odd    <= 1'b0;
      kill      <= 1'b0;
      in_pc     <= '0;
      fetch_pc  <= RESET_PC;
    end else begin
      state     <= inst_ready ? FETCH : WAIT_MEM;
      armed     <= 1'b1;
      kill      <= redirect;
      in_flight <= mem_enable;
      if (mem_enable) begin
        in_odd   <= fetch_pc[0];
        in_pc    <= fetch_pc;
        fetch_pc <= fetch_pc + (fetch_pc[0] ? 16'd1 : 16'd2);
      end
      if (redirect) fetch_pc <= redirect_pc;
    end
  end
endmodule

// File: tb/tb_reflet_fetch16.sv
// tb_reflet_fetch16: table vectors, hand sequences and a byte-stream scoreboard for reflet_fetch16
module tb_reflet_fetch16;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 1, inst_ready = 0, mem_enable, redirect = 0, inst_valid, inst_accept = 0;
  logic [14:0] mem_addr;
  logic [15:0] mem_data, redirect_pc = 0, inst_pc;
  logic [7:0]  inst_out;
  int          n_cmp = 0, n_bad = 0;
  logic        sb_on = 0;
  logic [15:0] exp_pc = 0;

  reflet_fetch16 #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .inst_ready(inst_ready), .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_accept(inst_accept)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memword(logic [14:0] w);
    case (w)
      15'd0:   return 16'h7E00;
      15'd1:   return 16'h0000;
      15'd2:   return 16'hF010;
      default: return ({1'b0, w} * 16'h9E37) ^ 16'hA55A;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(logic [15:0] a);
    logic [15:0] w;
    w = memword(a[15:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  always @(posedge clk) mem_data <= mem_enable ? memword(mem_addr) : 16'($urandom);

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Expected byte stream: consecutive pcs from the last reset/redirect target
  always @(negedge clk) if (sb_on) begin
    if (mem_enable && !inst_ready) check("issue_without_ready", 32'(mem_enable), 32'd0);
    if (reset) exp_pc = 16'h0000;
    else if (redirect) exp_pc = redirect_pc;
    else if (inst_valid && inst_accept) begin
      check("sb_pc", 32'(inst_pc), 32'(exp_pc));
      check("sb_ins", 32'(inst_out), 32'(byte_at(exp_pc)));
      exp_pc = exp_pc + 16'd1;
    end
  end

  typedef struct {
    logic        accept;
    logic        valid;
    logic [15:0] pc;
    logic [7:0]  ins;
  } vec_t;

  initial begin
    vec_t        tab [6];
    logic [15:0] wrap_pc [4];
    int          bytes, bad_en, bad_v, pops;
    logic        found;
    tab[0] = '{1'b1, 1'b1, 16'h0000, 8'h00};
    tab[1] = '{1'b1, 1'b1, 16'h0001, 8'h7E};
    tab[2] = '{1'b1, 1'b1, 16'h0002, 8'h00};
    tab[3] = '{1'b1, 1'b1, 16'h0003, 8'h00};
    tab[4] = '{1'b1, 1'b1, 16'h0004, 8'h10};
    tab[5] = '{1'b1, 1'b1, 16'h0005, 8'hF0};
    wrap_pc[0] = 16'hFFFE; wrap_pc[1] = 16'hFFFF; wrap_pc[2] = 16'h0000; wrap_pc[3] = 16'h0001;

    // reset, memory not ready
    cyc(); cyc(); reset = 0; sb_on = 1; #1;
    check("rst_mem_enable", 32'(mem_enable), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_inst_out", 32'(inst_out), 0);
    check("rst_inst_pc", 32'(inst_pc), 0);
    bad_en = 0; bad_v = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(); #1;
      if (mem_enable) bad_en++;
      if (inst_valid) bad_v++;
    end
    check("notready_enable_cycles", bad_en, 0);
    check("notready_valid_cycles", bad_v, 0);
    cyc(); inst_ready = 1; inst_accept = 1; #1;
    check("ready_issue", 32'(mem_enable), 1);
    check("ready_addr", 32'(mem_addr), 0);
    cyc(); #1;
    check("lat_valid_c1", 32'(inst_valid), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(); inst_accept = tab[i].accept; #1;
      check("tab_valid", 32'(inst_valid), 32'(tab[i].valid));
      check("tab_pc", 32'(inst_pc), 32'(tab[i].pc));
      check("tab_ins", 32'(inst_out), 32'(tab[i].ins));
    end

    // accept held low: exactly DEPTH bytes requested, then drain
    cyc(); reset = 1; inst_accept = 0;
    cyc(); reset = 0;
    bytes = 0;
    for (int k = 0; k < 16; k++) begin
      #1; if (mem_enable) bytes += 2;
      cyc();
    end
    #1;
    check("full_bytes_requested", bytes, DEPTH);
    check("full_no_issue", 32'(mem_enable), 0);
    check("full_head_pc", 32'(inst_pc), 0);
    check("full_head_ins", 32'(inst_out), 32'(byte_at(16'h0000)));
    inst_accept = 1;
    bad_v = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(); #1;
      if (!inst_valid) bad_v++;
    end
    check("drain_bubbles", bad_v, 0);

    // redirect to odd address with a read in flight
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(); #1;
      if (mem_enable) found = 1;
    end
    check("redir_issue_seen", 32'(found), 1);
    cyc(); redirect = 1; redirect_pc = 16'h0103; #1;
    check("redir_r_no_issue", 32'(mem_enable), 0);
    cyc(); redirect = 0; #1;
    check("redir_r1_valid", 32'(inst_valid), 0);
    check("redir_r1_issue", 32'(mem_enable), 1);
    check("redir_r1_addr", 32'(mem_addr), 32'h81);
    cyc(); #1;
    check("redir_r2_valid", 32'(inst_valid), 0);
    cyc(); #1;
    check("redir_r3_valid", 32'(inst_valid), 1);
    check("redir_r3_pc", 32'(inst_pc), 32'h0103);
    check("redir_r3_ins", 32'(inst_out), 32'(memword(15'h81) >> 8));
    cyc(); #1;
    check("redir_r4_pc", 32'(inst_pc), 32'h0104);
    check("redir_r4_ins", 32'(inst_out), 32'(byte_at(16'h0104)));

    // wrap-around
    cyc(); redirect = 1; redirect_pc = 16'hFFFE;
    cyc(); redirect = 0; #1;
    check("wrap_addr", 32'(mem_addr), 32'h7FFF);
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("wrap_valid", 32'(inst_valid), 1);
      check("wrap_pc", 32'(inst_pc), 32'(wrap_pc[i]));
    end

    // reset mid-stream
    cyc(); reset = 1;
    cyc(); reset = 0; #1;
    check("midrst_enable", 32'(mem_enable), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    check("midrst_valid", 32'(inst_valid), 0);
    check("midrst_ins", 32'(inst_out), 0);
    check("midrst_pc", 32'(inst_pc), 0);
    cyc(); #1;
    check("midrst_issue", 32'(mem_enable), 1);
    check("midrst_issue_addr", 32'(mem_addr), 0);
    cyc(); cyc(); #1;
    check("midrst_valid_back", 32'(inst_valid), 1);
    check("midrst_pc_back", 32'(inst_pc), 0);

    // inst_ready falls with a read outstanding
    cyc(); reset = 1; inst_accept = 0;
    cyc(); reset = 0;
    cyc(); #1;
    check("drop_first_issue", 32'(mem_enable), 1);
    cyc(); inst_ready = 0; #1;
    check("drop_no_issue", 32'(mem_enable), 0);
    cyc(); #1;
    check("drop_captured", 32'(inst_valid), 1);
    check("drop_captured_pc", 32'(inst_pc), 0);
    bad_en = 0; bad_v = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      if (mem_enable) bad_en++;
      if (!inst_valid || inst_pc != 16'h0000) bad_v++;
    end
    check("drop_idle_issue", bad_en, 0);
    check("drop_fifo_kept", bad_v, 0);
    cyc(); inst_ready = 1; inst_accept = 1; #1;
    check("drop_resume_issue", 32'(mem_enable), 1);
    check("drop_resume_addr", 32'(mem_addr), 1);

    // randomized traffic checked by the scoreboard
    pops = 0;
    for (int k = 0; k < 3000; k++) begin
      cyc();
      reset       = ($urandom % 400) == 0;
      redirect    = ($urandom % 25) == 0;
      redirect_pc = 16'($urandom);
      inst_ready  = ($urandom % 6) != 0;
      inst_accept = ($urandom % 3) != 0;
      #1;
      if (inst_valid && inst_accept && !redirect && !reset) pops++;
    end
    check("rand_progress", 32'(pops >= 500), 1);
    cyc(); reset = 0; redirect = 0; inst_accept = 0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reflet_fetch16.md
Name: reflet_fetch16

Overview:
- Instruction fetch stage directly downstream of the 16-bit instruction memory (RAM plus bootloader ROM, with a self-initialising first 16 words).
- Issues word reads once the memory reports inst_ready and splits each 16-bit word into 8-bit instructions.
- Holds the bytes in a small prefetch FIFO and hands them to the core with a valid/accept handshake.
- Supports redirect (jump) from the core, including flushing of any in-flight read.

Parameters:
- FIFO_DEPTH, 4, byte entries in the prefetch FIFO. Power of two, minimum 4.
- RESET_PC, 16'h0000, byte address fetched first after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_ready  in  1  memory initialisation complete; no read is issued while low
- mem_addr  out  15  word address to instruction memory
- mem_enable  out  1  read strobe; data is returned on mem_data exactly one cycle later
- mem_data  in  16  read data from instruction memory
- redirect  in  1  core jump request
- redirect_pc  in  16  byte address of the jump target
- inst_out  out  8  instruction byte at FIFO head
- inst_pc  out  16  byte address of inst_out
- inst_valid  out  1  inst_out/inst_pc are valid
- inst_accept  in  1  core consumes the head entry when inst_valid=1

Behaviour:
- Reset (cycle with reset=1): on the next edge, fetch_pc=RESET_PC, FIFO empty, in-flight flag cleared, mem_enable=0, mem_addr=0, inst_valid=0, inst_out=0, inst_pc=0. Reset mid-operation discards everything, including a pending read response.
- Byte order: byte address A maps to word A[15:1]. A[0]=0 selects mem_data[7:0]; A[0]=1 selects mem_data[15:8].
- FSM states:
  - WAIT_MEM: entered from reset. Moves to FETCH on the first cycle inst_ready=1.
  - FETCH: steady operation. Returns to WAIT_MEM if inst_ready falls. The FIFO is retained and a read already in flight is still captured.
- Issue rule (FETCH only): assert mem_enable with mem_addr=fetch_pc[15:1] when free_slots minus bytes_in_flight >= 2 and redirect=0. At most one read is outstanding per cycle; back-to-back issue is allowed.
- Response handling: one cycle after issue, push the bytes into the FIFO.
  - Two bytes (A then A+1) if the issue address was even.
  - One byte (high half) if odd, because fetch_pc was odd after a redirect.
  - fetch_pc advances by 2, or by 1 for an odd start, at issue time.
- Address arithmetic is 16-bit modulo: 0xFFFE+2 wraps to 0x0000, and 0xFFFF+1 wraps to 0x0000.
- Output: FIFO head is registered. inst_valid=1 iff the FIFO is non-empty. A pop occurs on inst_valid & inst_accept. Push and pop may occur in the same cycle.
- Latency: read issued in cycle N, data captured at end of N+1, inst_valid=1 in N+2.
- Redirect, asserted in cycle R:
  - fetch_pc := redirect_pc.
  - FIFO flushed.
  - Any response arriving in R+1 is dropped, tracked with a kill flag.
  - inst_valid=0 in R+1, first new read issued in R+1, new instruction valid in R+3.
- Redirect has priority over inst_accept and over issue in the same cycle.
- Full FIFO: no issue. Occupancy never exceeds FIFO_DEPTH; this is guaranteed by the reservation rule.
- inst_accept while inst_valid=0 is ignored.

Decomposition:
- Shared package reflet_fetch_pkg holds:
  - Address widths: BYTE_ADDR_W=16, WORD_ADDR_W=15.
  - FSM state encoding: WAIT_MEM, FETCH.
  - FIFO entry struct: {pc[15:0], byte[7:0]}.
- One natural sub-module, reflet_fetch_fifo:
  - Synchronous byte FIFO with 1- or 2-byte push, 1-byte pop, flush, and occupancy count.
  - Same clock and active-high synchronous reset.

Test Plan:
- Reset then inst_ready held low for 20 cycles -> mem_enable stays 0 and inst_valid stays 0. Raise inst_ready at cycle C -> mem_addr=0 at C, inst_valid at C+2 with inst_pc=0x0000 and inst_out=mem[0][7:0].
- Continuous accept, memory words 0x7E00,0x0000,0xF010 at words 0..2 -> byte stream 00,7E,00,00,10,F0 with inst_pc 0..5 and no bubbles after the first valid.
- inst_accept held low -> exactly FIFO_DEPTH bytes buffered, no further mem_enable. Then accept one byte per cycle -> each pop is followed by refill with no lost or duplicated pc.
- redirect_pc=0x0103 asserted while a read is in flight -> stale data dropped, inst_valid=0 next cycle, mem_addr=0x0081, first output byte = mem[0x81][15:8] with inst_pc=0x0103, then pc 0x0104.
- redirect_pc=0xFFFE -> pcs 0xFFFE,0xFFFF,0x0000,0x0001 (wrap). Separately, assert reset for one cycle mid-stream -> all outputs 0 next cycle and fetch restarts at RESET_PC.
- inst_ready falls with one read outstanding -> that response is still captured, no new issue until inst_ready returns, FIFO contents preserved.
